sram_req_arbiter: RTL and testbench

- Parametrised arbiter merging CH SRAM-like master channels onto one SRAM-like slave port.
- Upstream channels are request/addr_ok/data_ok: index 0 = instruction fetch, index 1 = data access, higher indices reserved for future masters.
- Tracks up to DEPTH outstanding transactions and routes in-order responses back to the issuing channel.
- Sits between the pipeline stages and the bus bridge; it replaces the current direct inst/data SRAM wiring.

---
 rtl/sram_req_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges CH SRAM-like master channels onto one slave port.
// Index 0 = instruction fetch, 1 = data access. Up to DEPTH transactions are
// tracked in a FIFO of issuing-channel indices so that in-order responses
// are routed back to the issuing channel.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration instead
// of fixed highest-index priority.
module sram_req_arbiter #(
  parameter int unsigned CH     = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [CH-1:0]              ch_req,
  input  logic [CH-1:0]              ch_wr,
  input  logic [2*CH-1:0]            ch_size,
  input  logic [CH*DATA_W/8-1:0]     ch_wstrb,
  input  logic [CH*ADDR_W-1:0]       ch_addr,
  input  logic [CH*DATA_W-1:0]       ch_wdata,
  output logic [CH-1:0]              ch_addr_ok,
  output logic [CH-1:0]              ch_data_ok,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       req,
  output logic                       wr,
  output logic [1:0]                 size,
  output logic [DATA_W/8-1:0]        wstrb,
  output logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          wdata,
  input  logic                       addr_ok,
  input  logic                       data_ok,
  input  logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_unexp
);

  localparam int unsigned IW = $clog2(CH);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = DATA_W/8;

  logic [IW-1:0] fifo_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          err_q, err_d;
  logic [IW-1:0] win;
  logic          found;
  logic          accept, pop;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] cand;
`endif

  // Winner selection; an active lock overrides the arbitration result
  always_comb begin
    win   = '0;
    found = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    cand  = '0;
    // Walk the search order backwards so the last hit is the first
    // candidate after the pointer.
    for (int unsigned k = CH; k >= 1; k--) begin
      cand = IW'((32'(rr_q) + k) % CH);
      if (ch_req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
`else
    for (int unsigned i = 0; i < CH; i++) begin
      if (ch_req[i]) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
`endif
    if (lock_q) begin
      win   = lock_idx_q;
      found = 1'b1;
    end
  end

  // Slave-side field mux from the winning channel
  always_comb begin
    wr    = 1'b0;
    size  = '0;
    wstrb = '0;
    addr  = '0;
    wdata = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (win == IW'(i)) begin
        wr    = ch_wr[i];
        size  = ch_size[2*i +: 2];
        wstrb = ch_wstrb[i*SW +: SW];
        addr  = ch_addr[i*ADDR_W +: ADDR_W];
        wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Handshakes, response routing and next-state for tracking/lock/error
  always_comb begin
    req        = found && (cnt_q != CW'(DEPTH));
    accept     = req && addr_ok;
    pop        = data_ok && (cnt_q != '0);
    ch_addr_ok = '0;
    ch_data_ok = '0;
    if (accept) ch_addr_ok[win] = 1'b1;
    if (pop)    ch_data_ok[fifo_q[head_q]] = 1'b1;
    ch_rdata   = rdata;

    head_d = pop    ? head_q + PW'(1) : head_q;
    tail_d = accept ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (req && !addr_ok) begin
      lock_d     = 1'b1;
      lock_idx_d = win;
    end else if (addr_ok) begin
      lock_d = 1'b0;
    end

    err_d = err_q | (data_ok && (cnt_q == '0));
`ifdef ARB_ROUND_ROBIN_EN
    rr_d = accept ? win : rr_q;
`endif
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= '0;
`endif
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // Tracking FIFO storage: issuing channel index per accepted request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (accept) begin
      fifo_q[tail_q] <= win;
    end
  end

  assign outstanding = cnt_q;
  assign err_unexp   = err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter (CH=2, DEPTH=4, fixed priority).
module tb_sram_req_arbiter;

  logic        clk;
  logic        resetn;
  logic [1:0]  ch_req, ch_wr;
  logic [3:0]  ch_size;
  logic [7:0]  ch_wstrb;
  logic [63:0] ch_addr, ch_wdata;
  logic [1:0]  ch_addr_ok, ch_data_ok;
  logic [31:0] ch_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [2:0]  outstanding;
  logic        err_unexp;

  int tests = 0;
  int fails = 0;

  logic [1:0]  exp_grant [$];
  logic [33:0] exp_resp  [$];
  logic [1:0]  mg;
  logic [33:0] mr;

  sram_req_arbiter #(.CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .outstanding(outstanding), .err_unexp(err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare whenever the DUT asserts a handshake
  always @(negedge clk) begin
    if (resetn) begin
      if (ch_addr_ok != 2'b00) begin
        tests++;
        if (exp_grant.size() == 0) begin
          fails++;
          $display("FAIL grant_unexpected act=%b exp=none", ch_addr_ok);
        end else begin
          mg = exp_grant.pop_front();
          if (ch_addr_ok !== mg) begin
            fails++;
            $display("FAIL grant act=%b exp=%b", ch_addr_ok, mg);
          end
        end
      end
      if (ch_data_ok != 2'b00) begin
        tests++;
        if (exp_resp.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected act=%b/%h exp=none", ch_data_ok, ch_rdata);
        end else begin
          mr = exp_resp.pop_front();
          if ({ch_data_ok, ch_rdata} !== mr) begin
            fails++;
            $display("FAIL resp act=%b/%h exp=%b/%h", ch_data_ok, ch_rdata, mr[33:32], mr[31:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b10, 2'b10, 2'b01};
    resetn   = 1'b0;
    ch_req   = '0;
    ch_wr    = '0;
    ch_size  = 4'b1010;
    ch_wstrb = 8'hff;
    ch_addr  = '0;
    ch_wdata = {32'hD1D1D1D1, 32'hD0D0D0D0};
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    rdata    = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unexp, 0);
    chk("rst_addr_ok", ch_addr_ok, 0);
    chk("rst_data_ok", ch_data_ok, 0);
    tick();
    resetn = 1'b1;

    // Single read on channel 0
    ch_req = 2'b01; ch_addr[31:0] = 32'h1C000000; addr_ok = 1'b1;
    exp_grant.push_back(2'b01);
    @(negedge clk);
    chk("single_req", req, 1);
    chk("single_addr", addr, 64'h1C000000);
    chk("single_size", size, 2);
    tick();
    ch_req = 2'b00; addr_ok = 1'b0;
    @(negedge clk);
    chk("single_out1", outstanding, 1);
    tick();
    tick();
    data_ok = 1'b1; rdata = 32'h12345678;
    exp_resp.push_back({2'b01, 32'h12345678});
    @(negedge clk);
    chk("single_out_pre", outstanding, 1);
    tick();
    data_ok = 1'b0;
    @(negedge clk);
    chk("single_out0", outstanding, 0);
    tick();

    // Contention: ch1 wins every cycle; from the 2nd cycle push and pop together
    ch_req = 2'b11; ch_addr[63:32] = 32'h20000000; addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_grant.push_back(2'b10);
      if (k > 0) begin
        data_ok = 1'b1; rdata = 32'hA0 + k;
        exp_resp.push_back({2'b10, 32'hA0 + k});
      end
      @(negedge clk);
      chk("cont_addr", addr, 64'h20000000);
      chk("cont_out", outstanding, 1'b1 && k > 0 ? 1 : 0);
      tick();
    end
    ch_req = 2'b00; addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hB0;
    exp_resp.push_back({2'b10, 32'hB0});
    @(negedge clk);
    chk("cont_out_end", outstanding, 1);
    tick();
    data_ok = 1'b0;
    @(negedge clk);
    chk("cont_out0", outstanding, 0);
    tick();

    // Lock stability: ch0 stalled, ch1 joins in cycle 2
    ch_addr = {32'h200, 32'h100}; ch_wr = 2'b01; ch_req = 2'b01; addr_ok = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) ch_req = 2'b11;
      @(negedge clk);
      chk("lock_addr", addr, 64'h100);
      chk("lock_wr", wr, 1);
      chk("lock_req", req, 1);
      tick();
    end
    addr_ok = 1'b1;
    exp_grant.push_back(2'b01);
    @(negedge clk);
    chk("lock_acc_addr", addr, 64'h100);
    tick();
    ch_req = 2'b10;
    exp_grant.push_back(2'b10);
    @(negedge clk);
    chk("lock_ch1_addr", addr, 64'h200);
    chk("lock_ch1_wr", wr, 0);
    tick();
    ch_req = 2'b00; addr_ok = 1'b0;
    @(negedge clk);
    chk("lock_out2", outstanding, 2);
    tick();
    data_ok = 1'b1; rdata = 32'hC0;
    exp_resp.push_back({2'b01, 32'hC0});
    tick();
    rdata = 32'hC1;
    exp_resp.push_back({2'b10, 32'hC1});
    tick();
    data_ok = 1'b0;
    @(negedge clk);
    chk("lock_out0", outstanding, 0);
    tick();

    // Full and ordering
    ch_wr = 2'b00; addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ch_req = seq[k];
      exp_grant.push_back(seq[k]);
      tick();
    end
    ch_req = 2'b01;
    @(negedge clk);
    chk("full_req", req, 0);
    chk("full_out", outstanding, 4);
    tick();
    data_ok = 1'b1; rdata = 32'hD0;
    exp_resp.push_back({2'b01, 32'hD0});
    @(negedge clk);
    chk("full_pop_noreq", req, 0);
    tick();
    rdata = 32'hD1;
    exp_resp.push_back({2'b10, 32'hD1});
    exp_grant.push_back(2'b01);
    @(negedge clk);
    chk("full_reassert", req, 1);
    chk("full_out3", outstanding, 3);
    tick();
    ch_req = 2'b00; addr_ok = 1'b0;
    rdata = 32'hD2; exp_resp.push_back({2'b10, 32'hD2});
    tick();
    rdata = 32'hD3; exp_resp.push_back({2'b01, 32'hD3});
    tick();
    rdata = 32'hD4; exp_resp.push_back({2'b01, 32'hD4});
    tick();
    data_ok = 1'b0;
    @(negedge clk);
    chk("full_out0", outstanding, 0);
    tick();

    // Spurious response
    data_ok = 1'b1; rdata = 32'hEE;
    @(negedge clk);
    chk("spur_data_ok", ch_data_ok, 0);
    chk("spur_err_pre", err_unexp, 0);
    tick();
    data_ok = 1'b0;
    @(negedge clk);
    chk("spur_err", err_unexp, 1);
    tick();
    tick();
    @(negedge clk);
    chk("spur_sticky", err_unexp, 1);
    tick();
    #1 resetn = 1'b0;
    #1 chk("spur_rst_clr", err_unexp, 0);
    resetn = 1'b1;
    tick();

    // Async reset with two requests in flight
    ch_req = 2'b01; addr_ok = 1'b1;
    exp_grant.push_back(2'b01);
    tick();
    ch_req = 2'b10;
    exp_grant.push_back(2'b10);
    tick();
    ch_req = 2'b00; addr_ok = 1'b0;
    @(negedge clk);
    chk("mid_out2", outstanding, 2);
    #2 resetn = 1'b0; data_ok = 1'b1;
    #1 chk("mid_rst_out", outstanding, 0);
    chk("mid_rst_data_ok", ch_data_ok, 0);
    chk("mid_rst_req", req, 0);
    #1 resetn = 1'b1; data_ok = 1'b0;
    tick();
    data_ok = 1'b1; rdata = 32'hF0;
    @(negedge clk);
    chk("post_rst_data_ok", ch_data_ok, 0);
    tick();
    data_ok = 1'b0;
    @(negedge clk);
    chk("post_rst_err", err_unexp, 1);

    chk("grants_drained", exp_grant.size(), 0);
    chk("resps_drained", exp_resp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
